// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end of the 8-bit CPU.
// Owns PC and IR, fetches instruction bytes over a req/ack handshake,
// resolves jumps from the decoder outputs and the ALU Z/C flags, and
// issues a one-cycle execute strobe per instruction.
//
// Optional feature macro: FETCH_SEQ_SINGLE_STEP_EN
//   When defined, adds a `step` input; each instruction must be started by
//   run=1 together with step=1, and the sequencer always returns to IDLE
//   after EXEC.
module fetch_sequencer #(
  parameter int ADDR_W = 4  // legal range 4..8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [7:0]        ir,
  output logic              ir_valid,
  input  logic              dec_jump,
  input  logic              dec_jumpz,
  input  logic              dec_jumpnz,
  input  logic              dec_jumpc,
  input  logic              dec_jumpnc,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic              exec_en,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [7:0]        ir_q,    ir_d;
  logic              take;
  logic              start;

  // Branch resolution; flags hold the previous instruction's result here.
  always_comb begin
    take = dec_jump
         | (dec_jumpz  &  flag_z)
         | (dec_jumpnz & ~flag_z)
         | (dec_jumpc  &  flag_c)
         | (dec_jumpnc & ~flag_c);
  end

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  // A held step is deliberately not edge-detected: one instruction per pass.
  always_comb start = run & step;
`else
  always_comb start = run;
`endif

  // Next-state, PC and IR update logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // run is not consulted: an issued request always runs to its ack.
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Jump target is the low nibble of IR, zero-extended to the PC width.
        pc_d = take ? ADDR_W'(ir_q[3:0]) : pc_q + ADDR_W'(1);
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        state_d = ST_IDLE;
`else
        state_d = run ? ST_FETCH : ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over all moves.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    imem_addr = pc_q;
    ir        = ir_q;
    imem_req  = (state_q == ST_FETCH);
    ir_valid  = (state_q == ST_DECODE) || (state_q == ST_EXEC);
    exec_en   = (state_q == ST_EXEC);
    busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (ADDR_W=4).
// Memory responder pushes the expected instruction byte when it acks a
// fetch; the monitor pops and checks it on each exec_en, then advances a
// reference PC. Build with +define+FETCH_SEQ_SINGLE_STEP_EN for the step test.
module tb_fetch_sequencer;

  localparam int ADDR_W = 4;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  localparam int EXEC_GAP = 4;
`else
  localparam int EXEC_GAP = 3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic              step;
`endif
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_ack;
  logic [7:0]        imem_data;
  logic [7:0]        ir;
  logic              ir_valid;
  logic              dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc;
  logic              flag_z, flag_c;
  logic              exec_en;
  logic              busy;

  // Bench-side control and reference state.
  logic [7:0] mem [16];
  logic [7:0] sb_q [$];
  logic [3:0] model_pc;
  logic       jz_en;
  logic       resp_en;
  logic       gap_chk;
  int         ack_wait;
  int         wait_cnt;
  int         req_len;
  int         cyc;
  int         last_exec;
  int         exec_cnt;
  int         n_checks;
  int         n_err;

  fetch_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .dec_jump   (dec_jump),
    .dec_jumpz  (dec_jumpz),
    .dec_jumpnz (dec_jumpnz),
    .dec_jumpc  (dec_jumpc),
    .dec_jumpnc (dec_jumpnc),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .exec_en    (exec_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Minimal decoder stand-in: 8'h95 decodes as jumpz when enabled.
  assign dec_jumpz = jz_en & (ir == 8'h95);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor and memory responder, both acting on the falling edge.
  initial begin
    logic [7:0] d;
    logic       tk;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    wait_cnt  = 0;
    req_len   = 0;
    cyc       = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req) req_len++;
      else          req_len = 0;
      if (exec_en) begin
        exec_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_depth", sb_q.size(), 1);
        end else begin
          d  = sb_q.pop_front();
          check("exec_ir", ir, d);
          check("exec_ir_valid", ir_valid, 1);
          tk = jz_en && (d == 8'h95) && flag_z;
          model_pc = tk ? d[3:0] : model_pc + 4'd1;
        end
        if (gap_chk && last_exec >= 0) check("exec_gap", cyc - last_exec, EXEC_GAP);
        last_exec = cyc;
      end
      if (resp_en) begin
        if (imem_req) begin
          if (wait_cnt >= ack_wait) begin
            check("fetch_addr", imem_addr, model_pc);
            check("req_len", req_len, ack_wait + 1);
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            sb_q.push_back(mem[model_pc]);
            wait_cnt  = 0;
          end else begin
            imem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          imem_ack = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    model_pc  = 4'd0;
    sb_q.delete();
    last_exec = -1;
  endtask

  task automatic wait_execs(input int target, input int budget);
    int n = 0;
    while (exec_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exec_cnt < target) check("exec_timeout", exec_cnt, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) check("req_timeout", imem_req, 1);
  endtask

  initial begin
    int base;
    rst = 1'b1; run = 1'b0;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    dec_jump = 1'b0; dec_jumpnz = 1'b0; dec_jumpc = 1'b0; dec_jumpnc = 1'b0;
    flag_z = 1'b0; flag_c = 1'b0; jz_en = 1'b0;
    resp_en = 1'b1; gap_chk = 1'b0; ack_wait = 0;
    exec_cnt = 0; n_checks = 0; n_err = 0; last_exec = -1; model_pc = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h40;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_addr", imem_addr, 0);
    check("rst_ir", ir, 8'h00);
    check("rst_req", imem_req, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_exec_en", exec_en, 0);
    check("rst_busy", busy, 0);

    // Straight-line add stream, zero-wait ack, 17 instructions covers PC wrap.
    do_reset();
    gap_chk = 1'b1;
    run = 1'b1;
    wait_execs(exec_cnt + 17, 200);
    run = 1'b0;
    gap_chk = 1'b0;
    wait_idle();

    // jumpz at address 0 with Z set: next fetch at 5.
    mem[0] = 8'h95;
    do_reset();
    jz_en = 1'b1; flag_z = 1'b1;
    run = 1'b1;
    wait_execs(exec_cnt + 3, 100);
    run = 1'b0;
    wait_idle();
    check("jz_taken_end_pc", imem_addr, model_pc);

    // jumpz with Z clear: falls through to 1.
    do_reset();
    flag_z = 1'b0;
    run = 1'b1;
    wait_execs(exec_cnt + 3, 100);
    run = 1'b0;
    wait_idle();
    check("jz_fall_end_pc", imem_addr, 4'd3);
    mem[0] = 8'h40; jz_en = 1'b0;

    // Ack delayed 3 cycles; run drops mid-wait, instruction still completes.
    do_reset();
    ack_wait = 3;
    base = exec_cnt;
    run = 1'b1;
    wait_req();
    @(negedge clk);
    run = 1'b0;
    wait_idle();
    check("delay_execs", exec_cnt - base, 1);
    check("delay_busy", busy, 0);
    check("delay_pc", imem_addr, 4'd1);
    ack_wait = 0;

    // Reset while in FETCH, late ack the cycle after.
    do_reset();
    resp_en = 1'b0;
    imem_ack = 1'b0;
    base = exec_cnt;
    run = 1'b1;
    wait_req();
    rst = 1'b1;
    @(negedge clk);
    check("rst_fetch_req_drop", imem_req, 0);
    rst = 1'b0; run = 1'b0;
    imem_ack = 1'b1; imem_data = 8'hAB;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_pc", imem_addr, 0);
    check("late_ack_ir", ir, 8'h00);
    check("late_ack_req", imem_req, 0);
    check("late_ack_busy", busy, 0);
    check("late_ack_execs", exec_cnt - base, 0);
    resp_en = 1'b1;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    // Two single-cycle step pulses ten cycles apart: exactly two instructions.
    do_reset();
    step = 1'b0;
    run = 1'b1;
    base = exec_cnt;
    repeat (3) @(negedge clk);
    check("step_hold_idle", busy, 0);
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (9) @(negedge clk);
    end
    check("step_execs", exec_cnt - base, 2);
    check("step_pc", imem_addr, 4'd2);
    check("step_busy", busy, 0);
    run = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end stage of the 8-bit CPU: owns the program counter (PC) and instruction register (IR).
- Fetches instruction bytes from instruction memory over a req/ack handshake and presents IR to the instruction decoder's `a` input.
- Consumes the decoder's jump outputs together with the ALU Z/C flags to choose the next PC.
- Issues a one-cycle execute strobe to the datapath for every instruction.

Parameters:
- ADDR_W, 4, PC/instruction-address width; legal range 4..8.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- run  input  1  level; high = sequencer may fetch/execute
- imem_addr  output  ADDR_W  instruction address (= PC)
- imem_req  output  1  fetch request
- imem_ack  input  1  memory returns imem_data this cycle
- imem_data  input  8  instruction byte
- ir  output  8  instruction register, drives decoder `a`
- ir_valid  output  1  high in DECODE and EXEC
- dec_jump  input  1  decoder: unconditional jump
- dec_jumpz  input  1  decoder: jump if Z
- dec_jumpnz  input  1  decoder: jump if !Z
- dec_jumpc  input  1  decoder: jump if C
- dec_jumpnc  input  1  decoder: jump if !C
- flag_z  input  1  ALU zero flag, registered by datapath
- flag_c  input  1  ALU carry flag, registered by datapath
- exec_en  output  1  one-cycle datapath execute strobe
- busy  output  1  high in any state except IDLE

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC. Encoding is free; only the state names are normative.
- Reset values (on the rst edge):
  - state=IDLE, pc=0, ir=8'h00.
  - imem_req=0, ir_valid=0, exec_en=0, busy=0.
- Output decode:
  - imem_addr = pc at all times.
  - imem_req = (state==FETCH), combinational from state.
  - ir_valid = (state==DECODE || state==EXEC).
  - exec_en = (state==EXEC).
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req held high until imem_ack=1 is sampled.
  - On the ack edge: ir <= imem_data, go to DECODE. Zero-wait ack in the first FETCH cycle is legal.
  - run falling during FETCH does not abort the fetch; the request stays up until ack.
- DECODE:
  - One cycle for the decoder outputs to settle; always go to EXEC.
- EXEC:
  - exec_en=1 for exactly this cycle.
  - Branch condition `take` = dec_jump | (dec_jumpz & flag_z) | (dec_jumpnz & ~flag_z) | (dec_jumpc & flag_c) | (dec_jumpnc & ~flag_c).
  - If take: pc <= {zero-extend ir[3:0] to ADDR_W}. Otherwise pc <= pc+1, mod 2^ADDR_W (wraps from all-ones to 0).
  - Next state: FETCH if run=1, else IDLE.
- Latency: one instruction = FETCH wait cycles + 3 (minimum 3 cycles with zero-wait ack).
- Flags are sampled in EXEC. They reflect the previous instruction's result; the datapath updates flags on the exec_en edge.
- imem_ack outside FETCH is ignored; IR is unchanged.
- Reset mid-operation: rst wins over every transition in the same cycle.
  - imem_req drops one edge later.
  - A late ack arriving after reset is ignored (state is IDLE).
- More than one dec_jump* high at once is not expected from the decoder; the OR above is still the defined result.

Optional Feature:
- Macro: FETCH_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port `step` (1 bit).
  - After EXEC the sequencer always enters IDLE, ignoring run.
  - IDLE leaves to FETCH only on a cycle with run=1 and step=1, so exactly one instruction executes per step pulse.
  - A held `step` causes one instruction per 4+ cycles; this is not edge-detected.
- When undefined: no `step` port; behaviour exactly as in Behaviour.

Test Plan:
- Reset, run=1, zero-wait memory returning 8'h40 (add) at addresses 0,1,2:
  - imem_addr sequence 0,1,2; exec_en every 3rd cycle; ir=8'h40.
- ADDR_W=4, PC at 4'hF, non-jump instruction executes: next imem_addr=4'h0 (wrap).
- IR=8'h95 (jumpz to 5), decoder jumpz=1:
  - flag_z=1: next imem_addr=4'h5.
  - flag_z=0: next imem_addr=pc+1.
- Memory ack delayed 3 cycles:
  - imem_req high for 4 cycles, IR captures the data on the ack cycle.
  - run dropped mid-wait: the instruction still completes, then state is IDLE with busy=0.
- rst asserted in FETCH, ack arrives the cycle after:
  - pc=0, ir=8'h00, no exec_en, imem_req=0.
- With FETCH_SEQ_SINGLE_STEP_EN: run=1, two 1-cycle step pulses 10 cycles apart produce exactly two exec_en pulses; imem_addr goes 0→1→2.
